// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared types and constants for the Matrix Acceleration Unit datapath:
// the FP16 storage format, its exponent limits, and the bit positions of the
// result status flags produced by the output packer.
// -----------------------------------------------------------------------------
package mau_pkg;

    // IEEE-754 binary16 exponent bias and the all-ones (Inf/NaN) exponent code.
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;

    // The multiplier lane delivers mantissas scaled by 2^-18, i.e. the value of
    // a beat is in_mant * 2^(in_exp - FP16_BIAS - MANT_SCALE).
    localparam int MANT_SCALE = 18;

    // Bit positions within the 3-bit status flag vector.
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

endpackage

// File: rtl/mau_lzc.sv
// -----------------------------------------------------------------------------
// mau_lzc
// Combinational leading-zero counter.
//   mant_i  [M_WIDTH-1:0]        value to scan, MSB first
//   count_o [$clog2(M_WIDTH+1)]  number of zeros above the leading one;
//                                M_WIDTH when mant_i is all zeros
// -----------------------------------------------------------------------------
module mau_lzc #(
    parameter int M_WIDTH = 20,
    parameter int LZ_W    = $clog2(M_WIDTH + 1)
) (
    input  logic [M_WIDTH-1:0] mant_i,
    output logic [LZ_W-1:0]    count_o
);

    always_comb begin
        // NOTE: count_o gets its all-zero value before the loop so every path
        // assigns it; without this default the loop would infer a latch.
        count_o = LZ_W'(M_WIDTH);
        // Scanning upward lets the highest set bit make the final assignment.
        for (int i = 0; i < M_WIDTH; i++) begin
            if (mant_i[i]) begin
                count_o = LZ_W'(M_WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/mau_result_packer.sv
// -----------------------------------------------------------------------------
// mau_result_packer
// Normalizes, rounds (round-to-nearest-even) and packs the extended-precision
// multiplier lane output into FP16. Two-stage valid/ready pipeline with full
// backpressure; overflow saturates to infinity, underflow flushes to zero.
//   clk, reset             single clock, synchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready is 0 during reset)
//   in_sign, in_exp,       sign, biased exponent and unnormalized mantissa;
//   in_mant                value = (-1)^sign * in_mant * 2^(in_exp - 15 - 18)
//   out_valid / out_ready  output handshake
//   out_result             FP16 {sign, exp[4:0], frac[9:0]}
//   out_flags              [0] inexact, [1] underflow, [2] overflow
// -----------------------------------------------------------------------------
module mau_result_packer
    import mau_pkg::*;
#(
    parameter int M_WIDTH = 20,
    parameter int E_WIDTH = 5,
    parameter int F_WIDTH = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [E_WIDTH-1:0] in_exp,
    input  logic [M_WIDTH-1:0] in_mant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_result,
    output logic [2:0]         out_flags
);

    localparam int LZ_W = $clog2(M_WIDTH + 1);
    localparam int EI_W = E_WIDTH + 2;  // signed working exponent width

    // After normalization the leading one sits at bit M_WIDTH-1, so the output
    // exponent is in_exp - lz + ((M_WIDTH-1) - MANT_SCALE). Input and output
    // share FP16_BIAS, so the bias cancels.
    localparam logic signed [EI_W-1:0] EXP_OFFSET =
        EI_W'((M_WIDTH - 1) - MANT_SCALE - FP16_BIAS + FP16_BIAS);
    localparam logic signed [EI_W-1:0] EXP_MAX_S  = EI_W'(FP16_EXP_MAX);
    localparam logic signed [EI_W-1:0] EXP_ZERO_S = '0;

    // ---------------------------------------------------------------- stage 1
    logic [LZ_W-1:0]    lz;
    logic               s1_valid_q;
    logic               s1_sign_q;
    logic [E_WIDTH-1:0] s1_exp_q;
    logic [M_WIDTH-1:0] s1_mant_q;
    logic [LZ_W-1:0]    s1_lz_q;

    logic               out_valid_q;
    logic [15:0]        out_result_q;
    logic [2:0]         out_flags_q;

    logic               out_adv;
    logic               in_fire;

    mau_lzc #(.M_WIDTH(M_WIDTH), .LZ_W(LZ_W)) u_lzc (
        .mant_i  (in_mant),
        .count_o (lz)
    );

    // A stage may load when it is empty or its content leaves this cycle.
    assign out_adv  = !out_valid_q || out_ready;
    assign in_ready = !reset && (!s1_valid_q || out_adv);
    assign in_fire  = in_valid && in_ready;

    // NOTE: payload registers carry no reset; the valid bits alone qualify
    // them, which keeps reset fan-out off the wide data path.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_sign_q <= in_sign;
            s1_exp_q  <= in_exp;
            s1_mant_q <= in_mant;
            s1_lz_q   <= lz;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [M_WIDTH-1:0]     norm_mant;
    logic [F_WIDTH-1:0]     frac;
    logic                   guard;
    logic                   sticky;
    logic                   lsb;
    logic                   round_up;
    logic [F_WIDTH:0]       frac_sum;
    logic signed [EI_W-1:0] e_norm;
    logic signed [EI_W-1:0] e_rnd;
    fp16_t                  result_d;
    logic [2:0]             flags_d;

    assign norm_mant = s1_mant_q << s1_lz_q;
    assign frac      = norm_mant[M_WIDTH-2 -: F_WIDTH];
    assign guard     = norm_mant[M_WIDTH-2-F_WIDTH];
    assign sticky    = |norm_mant[M_WIDTH-3-F_WIDTH:0];
    assign lsb       = norm_mant[M_WIDTH-1-F_WIDTH];
    assign round_up  = guard && (sticky || lsb);
    assign frac_sum  = {1'b0, frac} + (F_WIDTH + 1)'(round_up);

    // A fraction carry-out leaves the low bits of frac_sum at zero, so only the
    // exponent needs the bump.
    assign e_norm = $signed(EI_W'(s1_exp_q)) + EXP_OFFSET - $signed(EI_W'(s1_lz_q));
    assign e_rnd  = e_norm + $signed(EI_W'(frac_sum[F_WIDTH]));

    always_comb begin
        result_d      = '0;
        result_d.sign = s1_sign_q;
        flags_d       = '0;
        // A zero mantissa is the only case whose MSB stays clear after the shift.
        if (!norm_mant[M_WIDTH-1]) begin
            flags_d = '0;
        end else if (e_rnd >= EXP_MAX_S) begin
            result_d.exp                = '1;
            flags_d[FLAG_OVERFLOW]      = 1'b1;
            flags_d[FLAG_INEXACT]       = 1'b1;
        end else if (e_rnd <= EXP_ZERO_S) begin
            flags_d[FLAG_UNDERFLOW]     = 1'b1;
            flags_d[FLAG_INEXACT]       = 1'b1;
        end else begin
            result_d.exp                = e_rnd[E_WIDTH-1:0];
            result_d.frac               = frac_sum[F_WIDTH-1:0];
            flags_d[FLAG_INEXACT]       = guard || sticky;
        end
    end

    // ------------------------------------------------------- valid/out state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (out_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q <= result_d;
                    out_flags_q  <= flags_d;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_mau_result_packer.sv
// -----------------------------------------------------------------------------
// tb_mau_result_packer
// Self-checking bench for mau_result_packer: a table of directed vectors with
// hand-computed FP16 results and flags, followed by hand-written sequences for
// backpressure and reset in the middle of a stall.
// -----------------------------------------------------------------------------
module tb_mau_result_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [19:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        sign;
        logic [4:0]  v_exp;
        logic [19:0] mant;
        logic [15:0] res;
        logic [2:0]  flags;
    } vec_t;

    localparam int N_VEC = 13;
    vec_t vecs [N_VEC];
    int   bp_idx [4];

    always #5 clk = ~clk;

    mau_result_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_beat(input vec_t v);
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.v_exp;
        in_mant  = v.mant;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  next_in;
        logic accepted;

        //            sign  exp     mant        result    flags
        vecs[0]  = '{1'b0, 5'd15, 20'h40000, 16'h3C00, 3'b000}; // 1.0 exact
        vecs[1]  = '{1'b0, 5'd15, 20'h80000, 16'h4000, 3'b000}; // 2.0 exact
        vecs[2]  = '{1'b0, 5'd15, 20'h80100, 16'h4000, 3'b001}; // tie, even lsb
        vecs[3]  = '{1'b0, 5'd15, 20'h80300, 16'h4002, 3'b001}; // tie, odd lsb
        vecs[4]  = '{1'b0, 5'd30, 20'h80000, 16'h7C00, 3'b101}; // overflow
        vecs[5]  = '{1'b1, 5'd1,  20'h20000, 16'h8000, 3'b011}; // underflow
        vecs[6]  = '{1'b1, 5'd20, 20'h00000, 16'h8000, 3'b000}; // signed zero
        vecs[7]  = '{1'b0, 5'd15, 20'hFFFFF, 16'h4400, 3'b001}; // round carry
        vecs[8]  = '{1'b0, 5'd29, 20'hFFFFF, 16'h7C00, 3'b101}; // carry into Inf
        vecs[9]  = '{1'b0, 5'd30, 20'h00001, 16'h3000, 3'b000}; // max shift
        vecs[10] = '{1'b1, 5'd2,  20'h20000, 16'h8400, 3'b000}; // min normal
        vecs[11] = '{1'b0, 5'd29, 20'h80000, 16'h7800, 3'b000}; // top exponent
        vecs[12] = '{1'b0, 5'd0,  20'h80000, 16'h0400, 3'b000}; // exp 0 in, e=1
        bp_idx   = '{0, 3, 4, 6};

        // ---------------------------------------------------------- reset
        reset     = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset in_ready",   32'(in_ready),   32'h0);
        check("reset out_valid",  32'(out_valid),  32'h0);
        check("reset out_result", 32'(out_result), 32'h0);
        check("reset out_flags",  32'(out_flags),  32'h0);
        reset = 1'b0;

        // ---------------------------------------------------- vector table
        for (int k = 0; k < N_VEC; k++) begin
            @(negedge clk);
            drive_beat(vecs[k]);
            #1;
            check($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'h1);
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            #1;
            check($sformatf("vec%0d early out_valid", k), 32'(out_valid), 32'h0);
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d out_valid", k),  32'(out_valid),  32'h1);
            check($sformatf("vec%0d out_result", k), 32'(out_result), 32'(vecs[k].res));
            check($sformatf("vec%0d out_flags", k),  32'(out_flags),  32'(vecs[k].flags));
        end

        // ---------------------------------------------------- backpressure
        @(negedge clk);
        out_ready = 1'b0;
        drive_beat(vecs[bp_idx[0]]);
        #1;
        check("bp accept0 in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        drive_beat(vecs[bp_idx[1]]);
        #1;
        check("bp accept1 in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        drive_beat(vecs[bp_idx[2]]);
        #1;
        check("bp full in_ready",  32'(in_ready),   32'h0);
        check("bp full out_valid", 32'(out_valid),  32'h1);
        check("bp full out_result", 32'(out_result), 32'(vecs[bp_idx[0]].res));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("bp stall%0d in_ready", c),   32'(in_ready),   32'h0);
            check($sformatf("bp stall%0d out_valid", c),  32'(out_valid),  32'h1);
            check($sformatf("bp stall%0d out_result", c), 32'(out_result), 32'(vecs[bp_idx[0]].res));
            check($sformatf("bp stall%0d out_flags", c),  32'(out_flags),  32'(vecs[bp_idx[0]].flags));
        end

        out_ready = 1'b1;
        next_in   = 2;
        #1;
        for (int idx = 0; idx < 4; idx++) begin
            check($sformatf("bp drain%0d out_valid", idx),  32'(out_valid),  32'h1);
            check($sformatf("bp drain%0d out_result", idx), 32'(out_result), 32'(vecs[bp_idx[idx]].res));
            check($sformatf("bp drain%0d out_flags", idx),  32'(out_flags),  32'(vecs[bp_idx[idx]].flags));
            accepted = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (accepted) begin
                next_in++;
                if (next_in < 4) drive_beat(vecs[bp_idx[next_in]]);
                else             idle_inputs();
            end
            #1;
        end
        check("bp all beats accepted", 32'(next_in),   32'd4);
        check("bp drained out_valid",  32'(out_valid), 32'h0);

        // ------------------------------------------------- reset mid-stall
        @(negedge clk);
        out_ready = 1'b0;
        drive_beat(vecs[3]);
        @(posedge clk);
        @(negedge clk);
        drive_beat(vecs[4]);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rst stall out_valid", 32'(out_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("rst in_ready low", 32'(in_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst out_valid",  32'(out_valid),  32'h0);
        check("rst out_result", 32'(out_result), 32'h0);
        check("rst out_flags",  32'(out_flags),  32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        drive_beat(vecs[1]);
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post-rst early out_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post-rst out_valid",  32'(out_valid),  32'h1);
        check("post-rst out_result", 32'(out_result), 32'(vecs[1].res));
        check("post-rst out_flags",  32'(out_flags),  32'(vecs[1].flags));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post-rst no stale beat", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
